// File: rtl/cbc_stream_cipher.sv
// ---------------------------------------------------------------------------
// cbc_stream_cipher
//
// Streaming CBC block-cipher engine. It encrypts or decrypts a message of
// `len` blocks, each BW bits wide, and moves one block per valid/ready
// handshake. The result is registered, so an accepted input block appears
// on out_data one clock later. The engine sustains one block per cycle
// while the sink keeps out_ready high.
//
// Cipher primitive (K = latched key, rotates by one bit within BW):
//   E(x) = rotl1(x ^ K)          D(y) = rotr1(y) ^ K
//   encrypt: c = E(p ^ chain), chain <- c
//   decrypt: p = D(c) ^ chain, chain <- c
//
// Optional feature macro: CBC_STREAM_MAC_EN
//   When defined, adds the mac/mac_valid outputs. mac carries the final
//   chain value (the last ciphertext block) and mac_valid pulses with done.
//
// Parameters:
//   BW  block and key width in bits (>= 2)
//   CW  message-length counter width
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   pulse; latches mode/key/iv/len when IDLE
//   mode                    0 = encrypt, 1 = decrypt
//   key, iv, len            cipher key, initial chaining value, block count
//   in_valid/in_ready       input block handshake, in_data payload
//   out_valid/out_ready     output block handshake
//   out_data, out_last      output payload and last-block flag
//   busy                    engine in RUN or DRAIN
//   done                    one-cycle pulse after the final output handshake
//   mac, mac_valid          (CBC_STREAM_MAC_EN only) message MAC
// ---------------------------------------------------------------------------
module cbc_stream_cipher #(
    parameter int BW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [BW-1:0] key,
    input  logic [BW-1:0] iv,
    input  logic [CW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef CBC_STREAM_MAC_EN
    ,
    output logic [BW-1:0] mac,
    output logic          mac_valid
`endif
);

    localparam logic [CW-1:0] LEN_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] LEN_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BLK_ZERO = {BW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One-bit rotations within the block width.
    function automatic logic [BW-1:0] rotl1(input logic [BW-1:0] x);
        return {x[BW-2:0], x[BW-1]};
    endfunction

    function automatic logic [BW-1:0] rotr1(input logic [BW-1:0] x);
        return {x[0], x[BW-1:1]};
    endfunction

    // Block cipher forward and inverse transforms.
    function automatic logic [BW-1:0] blk_enc(input logic [BW-1:0] x,
                                              input logic [BW-1:0] k);
        return rotl1(x ^ k);
    endfunction

    function automatic logic [BW-1:0] blk_dec(input logic [BW-1:0] y,
                                              input logic [BW-1:0] k);
        return rotr1(y) ^ k;
    endfunction

    state_t        state_r;
    state_t        state_n_s;
    logic [BW-1:0] chain_r;
    logic [BW-1:0] key_r;
    logic          mode_r;
    logic [CW-1:0] len_r;
    logic [CW-1:0] count_r;
    logic [BW-1:0] out_data_r;
    logic          out_valid_r;
    logic          out_last_r;
    logic          busy_r;
    logic          done_r;

    logic          start_ok_s;
    logic          in_ready_s;
    logic          in_fire_s;
    logic          out_fire_s;
    logic          last_s;
    logic          final_fire_s;
    logic [BW-1:0] result_s;

    // Next-state, handshake qualification and cipher datapath.
    always_comb begin
        state_n_s    = state_r;
        in_ready_s   = 1'b0;
        in_fire_s    = 1'b0;
        final_fire_s = 1'b0;
        start_ok_s   = 1'b0;
        out_fire_s   = out_valid_r && out_ready;
        last_s       = ((count_r + LEN_ONE) == len_r);
        if (mode_r) begin
            result_s = blk_dec(in_data, key_r) ^ chain_r;
        end else begin
            result_s = blk_enc(in_data ^ chain_r, key_r);
        end
        case (state_r)
            ST_IDLE: begin
                // A zero-length message is dropped without a done pulse.
                start_ok_s = start && (len != LEN_ZERO);
                if (start_ok_s) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Ready whenever the output slot is empty or being emptied.
                in_ready_s = !out_valid_r || out_ready;
                in_fire_s  = in_valid && in_ready_s;
                if (in_fire_s && last_s) begin
                    state_n_s = ST_DRAIN;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                final_fire_s = out_fire_s && out_last_r;
                if (final_fire_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State, latched message parameters, chaining value and block counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            chain_r <= BLK_ZERO;
            key_r   <= BLK_ZERO;
            mode_r  <= 1'b0;
            len_r   <= LEN_ZERO;
            count_r <= LEN_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            busy_r  <= (state_n_s != ST_IDLE);
            done_r  <= final_fire_s;
            if (start_ok_s) begin
                mode_r  <= mode;
                key_r   <= key;
                chain_r <= iv;
                len_r   <= len;
                count_r <= LEN_ZERO;
            end else if (in_fire_s) begin
                // The chain always follows the ciphertext side of the block.
                chain_r <= mode_r ? in_data : result_s;
                count_r <= count_r + LEN_ONE;
            end else begin
                chain_r <= chain_r;
                count_r <= count_r;
            end
        end
    end

    // Output register: load on input handshake, hold under backpressure,
    // empty on output handshake when nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= BLK_ZERO;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (in_fire_s) begin
            out_data_r  <= result_s;
            out_valid_r <= 1'b1;
            out_last_r  <= last_s;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

`ifdef CBC_STREAM_MAC_EN
    logic [BW-1:0] mac_r;
    logic          mac_valid_r;

    // Capture the final chain value as the MAC when the message completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_r       <= BLK_ZERO;
            mac_valid_r <= 1'b0;
        end else begin
            mac_valid_r <= final_fire_s;
            if (final_fire_s) begin
                mac_r <= chain_r;
            end else begin
                mac_r <= mac_r;
            end
        end
    end

    assign mac       = mac_r;
    assign mac_valid = mac_valid_r;
`endif

endmodule

// File: tb/tb_cbc_stream_cipher.sv
// ---------------------------------------------------------------------------
// tb_cbc_stream_cipher
//
// Directed testbench for cbc_stream_cipher (BW=4, CW=8). Expected values are
// hand-computed with key=11, iv=9:
//   encrypt 5,3  -> 14,12      decrypt 14,12 -> 5,3      MAC = 12
// ---------------------------------------------------------------------------
module tb_cbc_stream_cipher;

    localparam int BW = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [BW-1:0] key;
    logic [BW-1:0] iv;
    logic [CW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef CBC_STREAM_MAC_EN
    logic [BW-1:0] mac;
    logic          mac_valid;
`endif

    int n_checks;
    int n_errors;

    cbc_stream_cipher #(.BW(BW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .key       (key),
        .iv        (iv),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef CBC_STREAM_MAC_EN
        ,
        .mac       (mac),
        .mac_valid (mac_valid)
`endif
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic m, input logic [CW-1:0] l);
        mode  = m;
        key   = 4'd11;
        iv    = 4'd9;
        len   = l;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Two-block message with the sink always ready.
    task automatic run_msg(input string tag, input logic m,
                           input logic [BW-1:0] d0, input logic [BW-1:0] d1,
                           input logic [BW-1:0] e0, input logic [BW-1:0] e1);
        out_ready = 1'b1;
        pulse_start(m, 8'd2);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d0;
        cycle();
        check_eq({tag, "_v0"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_d0"}, 32'(out_data), 32'(e0));
        check_eq({tag, "_l0"}, 32'(out_last), 32'd0);
        in_data = d1;
        cycle();
        check_eq({tag, "_d1"}, 32'(out_data), 32'(e1));
        check_eq({tag, "_l1"}, 32'(out_last), 32'd1);
        check_eq({tag, "_drain_rdy"}, 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        cycle();
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_vclr"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
`ifdef CBC_STREAM_MAC_EN
        check_eq({tag, "_macv"}, 32'(mac_valid), 32'd1);
        check_eq({tag, "_mac"}, 32'(mac), 32'd12);
`endif
        cycle();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        key       = 4'd0;
        iv        = 4'd0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        cycle();
        cycle();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Basic encrypt and decrypt messages.
        run_msg("enc", 1'b0, 4'd5, 4'd3, 4'd14, 4'd12);
        run_msg("dec", 1'b1, 4'd14, 4'd12, 4'd5, 4'd3);

        // Backpressure: second block must wait while the first is stalled.
        out_ready = 1'b1;
        pulse_start(1'b0, 8'd2);
        in_valid  = 1'b1;
        in_data   = 4'd5;
        cycle();
        check_eq("bp_first", 32'(out_data), 32'd14);
        in_data   = 4'd3;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);
            cycle();
            check_eq("bp_hold_data", 32'(out_data), 32'd14);
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_rdy", 32'(in_ready), 32'd1);
        cycle();
        check_eq("bp_second", 32'(out_data), 32'd12);
        check_eq("bp_second_last", 32'(out_last), 32'd1);
        in_valid = 1'b0;
        cycle();
        check_eq("bp_done", 32'(done), 32'd1);
        cycle();

        // Zero-length start is ignored.
        pulse_start(1'b0, 8'd0);
        check_eq("len0_busy", 32'(busy), 32'd0);
        check_eq("len0_rdy", 32'(in_ready), 32'd0);
        cycle();
        check_eq("len0_done", 32'(done), 32'd0);
        check_eq("len0_busy2", 32'(busy), 32'd0);

        // Start during RUN is ignored: new iv/len must not take effect.
        pulse_start(1'b0, 8'd2);
        in_valid = 1'b1;
        in_data  = 4'd5;
        iv       = 4'd0;
        len      = 8'd1;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        check_eq("rs_d0", 32'(out_data), 32'd14);
        check_eq("rs_l0", 32'(out_last), 32'd0);
        in_data = 4'd3;
        cycle();
        check_eq("rs_d1", 32'(out_data), 32'd12);
        check_eq("rs_l1", 32'(out_last), 32'd1);
        in_valid = 1'b0;
        cycle();
        check_eq("rs_done", 32'(done), 32'd1);
        cycle();

        // Reset in the middle of a message.
        pulse_start(1'b0, 8'd2);
        in_valid = 1'b1;
        in_data  = 4'd5;
        cycle();
        in_valid = 1'b0;
        check_eq("mr_first", 32'(out_data), 32'd14);
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", 32'(out_valid), 32'd0);
        check_eq("mr_data", 32'(out_data), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_rdy", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        cycle();
        pulse_start(1'b0, 8'd2);
        in_valid = 1'b1;
        in_data  = 4'd5;
        cycle();
        in_valid = 1'b0;
        check_eq("mr_restart", 32'(out_data), 32'd14);
        check_eq("mr_restart_last", 32'(out_last), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cbc_stream_cipher.md
Name: cbc_stream_cipher

Overview:
- Streaming, parametrised CBC block-cipher engine. Encrypts or decrypts a message of `len` blocks, each BW bits wide, one block per valid/ready handshake.
- Successor to the team's combinational fixed-width CBC decryptor. Adds encrypt mode, arbitrary block width, message framing, backpressure and a registered output.
- Sits between a block source (UART/switch front-end) and a block sink (display or TX path).

Parameters:
- BW, 4, block and key width in bits (≥2).
- CW, 8, width of message-length counter; max message = 2^CW-1 blocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; latches mode/key/iv/len. Honoured only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt.
- key  in  BW  cipher key.
- iv  in  BW  initial chaining value.
- len  in  CW  number of blocks in message.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine accepts input block this cycle.
- in_data  in  BW  plaintext (encrypt) or ciphertext (decrypt) block.
- out_valid  out  1  output block valid.
- out_ready  in  1  sink accepts output block.
- out_data  out  BW  result block.
- out_last  out  1  qualifies out_data as final block of message.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  1-cycle pulse after final output handshake.

Behaviour:
- Cipher primitive:
  - E(x) = rotl1(x ^ K).
  - D(y) = rotr1(y) ^ K.
  - Rotates are by one bit, within BW.
- Encrypt: c_i = E(p_i ^ chain); then chain ← c_i.
- Decrypt: p_i = D(c_i) ^ chain; then chain ← c_i (the input ciphertext).
- chain is loaded with iv on accepted start.
- Reset (async, any state):
  - state = IDLE.
  - chain, key, mode, count, out_data = 0.
  - out_valid, out_last, done, busy = 0.
  - in_ready = 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start with len ≠ 0 → latch mode/key/iv/len, count = 0, next state RUN.
  - start with len = 0 → ignored, stay IDLE, no done pulse.
- RUN:
  - in_ready = !out_valid || out_ready. Combinational; no dependence on in_valid.
  - Input handshake (in_valid && in_ready):
    - Compute result.
    - Register it into out_data, set out_valid next cycle (latency 1 clock).
    - Update chain, count++.
    - out_last = (count+1 == len).
  - On the handshake of block len → DRAIN.
- DRAIN:
  - in_ready = 0.
  - On final output handshake (out_valid && out_ready && out_last): out_valid → 0, done pulses 1 cycle, next state IDLE.
- Output register:
  - Holds out_data/out_last stable while out_valid && !out_ready.
  - Clears out_valid on handshake unless a new block is loaded in the same cycle.
- Simultaneous output handshake and new input in RUN: new block replaces the old one, out_valid stays 1. Full throughput is 1 block/cycle.
- start outside IDLE is ignored; latched parameters are unchanged.
- key/iv/mode/len changes after start have no effect until the next start.
- in_valid outside RUN is ignored; data is not consumed.

Optional Feature:
- Macro: CBC_STREAM_MAC_EN.
- Defined:
  - Extra outputs: mac[BW] and mac_valid (1 bit).
  - mac_valid pulses in the same cycle as done.
  - mac = final chain value, i.e. the last ciphertext block, for both modes. Held until next start; reset to 0.
- Undefined: ports and logic are absent; behaviour otherwise identical.

Test Plan:
- Encrypt: reset; start mode=0, key=11, iv=9, len=2; in 5, 3 with out_ready=1 → out 14, then 12 with out_last=1; done pulse; MAC build: mac=12.
- Decrypt: start mode=1, key=11, iv=9, len=2; in 14, 12 → out 5, 3 with out_last on 3; done pulse; MAC build: mac=12.
- Backpressure: encrypt as above with out_ready=0 for 5 cycles after the first output → out_data=14 held stable, in_ready=0, second block not consumed. Release → 12 follows, next cycle.
- Framing edge cases:
  - start with len=0 → stays IDLE, busy=0, no done.
  - start pulsed during RUN → ignored; message finishes with the original len.
- Reset mid-message: assert rst_n=0 after one of two blocks → all outputs 0, IDLE. A fresh start with iv=9 reproduces first output 14.
